// File: rtl/d_branch_ctrl_pkg.sv
// Shared encodings for the D-stage branch sequencer and its comparator.
// b_type values and FSM state encodings live here so the comparator and the
// control decoder agree on the same numbering.
package d_branch_ctrl_pkg;

  localparam logic [2:0] BT_BEQ  = 3'd0;
  localparam logic [2:0] BT_BNE  = 3'd1;
  localparam logic [2:0] BT_BHE  = 3'd2;
  localparam logic [2:0] BT_BHEL = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } br_state_e;

  // Codes 4-7 are reserved and never produce a taken branch.
  function automatic logic bt_reserved(input logic [2:0] bt);
    return bt[2];
  endfunction

  // Map comparator results to a branch decision. cmp_zero is already
  // qualified by the comparator for beq/bne, so both use it directly.
  function automatic logic branch_dec(input logic [2:0] bt,
                                      input logic       cmp_zero,
                                      input logic       cmp_result);
    logic d;
    case (bt)
      BT_BEQ, BT_BNE:  d = cmp_zero;
      BT_BHE, BT_BHEL: d = cmp_result;
      default:         d = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/d_branch_stat.sv
// Saturating branch statistics counters: resolved branches, taken branches
// and cycles spent stalling on operand readiness. Only instantiated when the
// BRANCH_STAT_EN macro is defined.
module d_branch_stat #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             resolved,
  input  logic             taken,
  input  logic             br_stall,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_taken,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Increment by one unless already at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    logic [CNT_W-1:0] r;
    r = v;
    if (en && (v != {CNT_W{1'b1}})) r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

  // Next counter values; taken only counts in the advance cycle.
  always_comb begin
    total_d = sat_inc(total_q, resolved);
    taken_d = sat_inc(taken_q, resolved & taken);
    stall_d = sat_inc(stall_q, br_stall);
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_q <= '0;
      taken_q <= '0;
      stall_q <= '0;
    end else begin
      total_q <= total_d;
      taken_q <= taken_d;
      stall_q <= stall_d;
    end
  end

  assign br_total     = total_q;
  assign br_taken     = taken_q;
  assign stall_cycles = stall_q;

endmodule

// File: rtl/d_branch_ctrl.sv
// Decode-stage branch sequencer. Waits for forwarded operands, resolves the
// branch through the D-stage comparator, and latches the decision while D is
// frozen by other stall sources so every branch resolves exactly once.
// Optional statistics counters and ports are enabled by defining BRANCH_STAT_EN.
module d_branch_ctrl
  import d_branch_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_br,
  input  logic [2:0]       b_type,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             ext_stall,
  input  logic             cmp_zero,
  input  logic             cmp_result,
  output logic [2:0]       cmp_type,
  output logic             br_stall,
  output logic             taken,
  output logic             flush_ds,
  output logic             resolved,
`ifdef BRANCH_STAT_EN
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_taken,
  output logic [CNT_W-1:0] stall_cycles,
`endif
  output logic             bad_type
);

  br_state_e state_q, state_d;
  logic      dec_q, dec_d;
  logic      lflush_q, lflush_d;
  logic      bad_q, bad_d;

  logic      ready;
  logic      dec_now;
  logic      flush_now;

  assign ready     = rs_ready & rt_ready;
  assign dec_now   = branch_dec(b_type, cmp_zero, cmp_result);
  assign flush_now = (b_type == BT_BHEL) & ~dec_now;
  assign cmp_type  = d_br ? b_type : 3'd0;
  assign bad_type  = bad_q;

  // Next state and the same-cycle stall/advance outputs.
  always_comb begin
    state_d  = state_q;
    dec_d    = dec_q;
    lflush_d = lflush_q;
    bad_d    = bad_q | (d_br & bt_reserved(b_type));
    br_stall = 1'b0;
    taken    = 1'b0;
    flush_ds = 1'b0;
    resolved = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (!d_br) begin
          state_d = ST_IDLE;
        end else if (!ready) begin
          br_stall = 1'b1;
          state_d  = ST_WAIT;
        end else if (ext_stall) begin
          // Freeze the decision now; forwarded operands may change while held.
          dec_d    = dec_now;
          lflush_d = flush_now;
          state_d  = ST_HOLD;
        end else begin
          taken    = dec_now;
          flush_ds = flush_now;
          resolved = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!d_br) begin
          dec_d    = 1'b0;
          lflush_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (!ext_stall) begin
          taken    = dec_q;
          flush_ds = lflush_q;
          resolved = 1'b1;
          dec_d    = 1'b0;
          lflush_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched decision and sticky reserved-type flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dec_q    <= 1'b0;
      lflush_q <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dec_q    <= dec_d;
      lflush_q <= lflush_d;
      bad_q    <= bad_d;
    end
  end

`ifdef BRANCH_STAT_EN
  d_branch_stat #(
    .CNT_W(CNT_W)
  ) u_stat (
    .clk          (clk),
    .reset        (reset),
    .resolved     (resolved),
    .taken        (taken),
    .br_stall     (br_stall),
    .br_total     (br_total),
    .br_taken     (br_taken),
    .stall_cycles (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_d_branch_ctrl.sv
// Directed bench for d_branch_ctrl: a cycle-by-cycle vector table covering
// the IDLE/WAIT/HOLD paths, plus hand-written reserved-type and reset sequences.
module tb_d_branch_ctrl;

  logic       clk;
  logic       reset;
  logic       d_br;
  logic [2:0] b_type;
  logic       rs_ready;
  logic       rt_ready;
  logic       ext_stall;
  logic       cmp_zero;
  logic       cmp_result;
  logic [2:0] cmp_type;
  logic       br_stall;
  logic       taken;
  logic       flush_ds;
  logic       resolved;
  logic       bad_type;
`ifdef BRANCH_STAT_EN
  logic [31:0] br_total;
  logic [31:0] br_taken;
  logic [31:0] stall_cycles;
`endif

  int n_cmp;
  int n_bad;

  d_branch_ctrl #(.CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .d_br         (d_br),
    .b_type       (b_type),
    .rs_ready     (rs_ready),
    .rt_ready     (rt_ready),
    .ext_stall    (ext_stall),
    .cmp_zero     (cmp_zero),
    .cmp_result   (cmp_result),
    .cmp_type     (cmp_type),
    .br_stall     (br_stall),
    .taken        (taken),
    .flush_ds     (flush_ds),
    .resolved     (resolved),
`ifdef BRANCH_STAT_EN
    .br_total     (br_total),
    .br_taken     (br_taken),
    .stall_cycles (stall_cycles),
`endif
    .bad_type     (bad_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       d_br;
    logic [2:0] bt;
    logic       rs;
    logic       rt;
    logic       ext;
    logic       cz;
    logic       cr;
    logic       e_stall;
    logic       e_taken;
    logic       e_flush;
    logic       e_res;
    logic [2:0] e_ct;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic db, input logic [2:0] bt, input logic rs, input logic rt,
                       input logic ext, input logic cz, input logic cr);
    d_br = db; b_type = bt; rs_ready = rs; rt_ready = rt;
    ext_stall = ext; cmp_zero = cz; cmp_result = cr;
  endtask

  // Outputs are checked mid-cycle, then the clock advances to the next cycle.
  task automatic check_outs(input string tag, input logic st, input logic tk,
                            input logic fl, input logic rv, input logic [2:0] ct);
    #2;
    chk({tag, ".br_stall"}, {2'b0, br_stall}, {2'b0, st});
    chk({tag, ".taken"},    {2'b0, taken},    {2'b0, tk});
    chk({tag, ".flush_ds"}, {2'b0, flush_ds}, {2'b0, fl});
    chk({tag, ".resolved"}, {2'b0, resolved}, {2'b0, rv});
    chk({tag, ".cmp_type"}, cmp_type, ct);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // d_br bt rs rt ext cz cr | stall taken flush res ct
    vecs[0]  = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0}; // beq taken, same cycle
    vecs[1]  = '{1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}; // no branch, cmp_type 0
    vecs[2]  = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1}; // bne rt not ready
    vecs[3]  = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1}; // still waiting
    vecs[4]  = '{1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1}; // equal -> not taken
    vecs[5]  = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2}; // bhe latch 1, HOLD
    vecs[6]  = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2}; // HOLD, cmp flips
    vecs[7]  = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2}; // HOLD
    vecs[8]  = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2}; // release: latched taken
    vecs[9]  = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3}; // bhel not taken: flush
    vecs[10] = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3}; // bhel taken: no flush
    vecs[11] = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3}; // bhel latch not-taken
    vecs[12] = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3}; // release: latched flush
    vecs[13] = '{1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}; // beq rs not ready
    vecs[14] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}; // WAIT->HOLD latch 1
    vecs[15] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0}; // release taken
    vecs[16] = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}; // WAIT
    vecs[17] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}; // d_br drops: no pulse
    vecs[18] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}; // HOLD latch 1
    vecs[19] = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}; // d_br drops in HOLD
    vecs[20] = '{1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1}; // fresh bne from IDLE
    vecs[21] = '{1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1}; // back-to-back taken

    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Reset state
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("reset.bad_type", {2'b0, bad_type}, 3'd0);
    next_cycle();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].d_br, vecs[i].bt, vecs[i].rs, vecs[i].rt, vecs[i].ext, vecs[i].cz, vecs[i].cr);
      check_outs($sformatf("v%0d", i), vecs[i].e_stall, vecs[i].e_taken,
                 vecs[i].e_flush, vecs[i].e_res, vecs[i].e_ct);
      next_cycle();
    end
    chk("pre_bad.bad_type", {2'b0, bad_type}, 3'd0);

    // Reserved type resolves not-taken and sets the sticky flag.
    drive(1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_outs("bt6", 1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
    next_cycle();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("bt6.bad_set", {2'b0, bad_type}, 3'd1);
    next_cycle();
    next_cycle();
    chk("bt6.bad_sticky", {2'b0, bad_type}, 3'd1);

    // Reserved type through HOLD still releases not-taken.
    drive(1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_outs("bt7_hold", 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
    next_cycle();
    drive(1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_outs("bt7_rel", 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    next_cycle();

    // Reset while in WAIT: IDLE afterwards, outputs and flag cleared.
    drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outs("rw_wait", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outs("rw_after", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("rw_after.bad_type", {2'b0, bad_type}, 3'd0);
    next_cycle();

    // Reset while in HOLD with a latched taken: next branch uses live result.
    drive(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_outs("rh_hold", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive(1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_outs("rh_after", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    next_cycle();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
